// File: rtl/mram_pkg.sv
// Shared types and constants for the MRAM read path: trit codes,
// group/page sizes, assembler FSM states and the FIFO entry layout.
package mram_pkg;

  localparam logic [1:0] TRIT_S0  = 2'b00;
  localparam logic [1:0] TRIT_S1  = 2'b01;
  localparam logic [1:0] TRIT_S2  = 2'b10;
  localparam logic [1:0] TRIT_ILL = 2'b11;

  localparam int TRITS_PER_BYTE = 5;
  localparam int PAGE_TRITS     = 729;

  typedef enum logic {
    S_ACCEPT,
    S_RETRY
  } state_t;

  typedef struct packed {
    logic [7:0] data;
    logic       err;
    logic       last;
  } entry_t;

  // Illegal code packs as State0.
  function automatic logic [1:0] trit_val(input logic [1:0] code);
    return (code == TRIT_ILL) ? TRIT_S0 : code;
  endfunction

endpackage

// File: rtl/mram_byte_fifo.sv
// Synchronous show-ahead FIFO of packed bytes {data, err, last}.
// Ports: clk, rst (sync, active-high), push/din, pop/dout, full, empty.
// Head fields read as zero while empty. Push is taken when not full or
// when a pop happens in the same cycle.
module mram_byte_fifo
  import mram_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push,
  input  entry_t din,
  input  logic   pop,
  output entry_t dout,
  output logic   full,
  output logic   empty
);

  localparam int AW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;

  entry_t        mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & !empty;
  assign do_push = push & (!full | do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mram_read_assembler.sv
// Packs the sense-amp trit stream into bytes (5 trits, base 3) and queues
// them for the page buffer with page-end flush and per-page error status.
// Ports: sa_* trit input, in_ready, reread_req, out_* byte handshake,
// page_err, overflow. Optional meta-stable re-read: MRA_RETRY_EN.
module mram_read_assembler
  import mram_pkg::*;
#(
  parameter int         FIFO_DEPTH = 4,
  parameter logic [2:0] MAX_RETRY  = 3'd2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sa_valid,
  input  logic [1:0] sa_trit,
  input  logic       sa_meta,
  input  logic       sa_last,
  input  logic       out_ready,
  output logic       in_ready,
  output logic       reread_req,
  output logic       out_valid,
  output logic [7:0] out_byte,
  output logic       out_err,
  output logic       out_last,
  output logic       page_err,
  output logic       overflow
);

`ifdef MRA_RETRY_EN
  localparam bit RETRY_ON = 1'b1;
`else
  localparam bit RETRY_ON = 1'b0;
`endif

  state_t     state;
  logic [7:0] acc;
  logic [6:0] weight;
  logic [2:0] idx;
  logic       grp_err;
  logic [2:0] retry_cnt;
  logic       new_page;
  logic       pend_valid;
  entry_t     pend;

  entry_t     head;
  logic       fifo_full;
  logic       fifo_empty;

  logic       retry_now;
  logic       take;
  logic       closes;
  logic       t_err;
  logic [7:0] sum;
  logic       pop;
  logic       pend_go;

  assign in_ready = !rst & !fifo_full;

  always_comb begin
    retry_now = RETRY_ON & sa_valid & in_ready & sa_meta
              & (retry_cnt < MAX_RETRY);
    take      = sa_valid & in_ready & !retry_now;
    closes    = take & ((idx == 3'(TRITS_PER_BYTE - 1)) | sa_last);
    t_err     = (sa_trit == TRIT_ILL) | sa_meta;
    sum       = acc + 8'(weight) * 8'(trit_val(sa_trit));
    pop       = out_ready & !fifo_empty;
    pend_go   = pend_valid & (!fifo_full | pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_ACCEPT;
      acc        <= '0;
      weight     <= 7'd1;
      idx        <= '0;
      grp_err    <= 1'b0;
      retry_cnt  <= '0;
      new_page   <= 1'b1;
      pend_valid <= 1'b0;
      pend       <= '0;
      reread_req <= 1'b0;
      page_err   <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      reread_req <= retry_now;
      if (sa_valid & !in_ready) begin
        overflow <= 1'b1;
      end
      if (pend_go) begin
        pend_valid <= 1'b0;
      end
      if (retry_now) begin
        retry_cnt <= retry_cnt + 1'b1;
        state     <= S_RETRY;
      end
      if (take) begin
        retry_cnt <= '0;
        state     <= S_ACCEPT;
        new_page  <= sa_last;
        if (new_page) begin
          page_err <= 1'b0;
        end
        if (closes) begin
          acc        <= '0;
          weight     <= 7'd1;
          idx        <= '0;
          grp_err    <= 1'b0;
          pend_valid <= 1'b1;
          pend.data  <= sum;
          pend.err   <= grp_err | t_err;
          pend.last  <= sa_last;
          if (grp_err | t_err) begin
            page_err <= 1'b1;
          end
        end else begin
          acc     <= sum;
          weight  <= 7'(weight * 7'd3);
          idx     <= idx + 1'b1;
          grp_err <= grp_err | t_err;
        end
      end
    end
  end

  mram_byte_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (pend_valid),
    .din  (pend),
    .pop  (pop),
    .dout (head),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  assign out_valid = !fifo_empty;
  assign out_byte  = head.data;
  assign out_err   = head.err;
  assign out_last  = head.last;

endmodule

// File: tb/tb_mram_read_assembler.sv
// Scoreboard bench for mram_read_assembler: a trit model pushes expected
// bytes, a negedge monitor pops and compares them as the DUT emits.
module tb_mram_read_assembler;
  import mram_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sa_valid = 1'b0;
  logic [1:0] sa_trit = 2'b00;
  logic       sa_meta = 1'b0;
  logic       sa_last = 1'b0;
  logic       out_ready = 1'b1;
  logic       in_ready;
  logic       reread_req;
  logic       out_valid;
  logic [7:0] out_byte;
  logic       out_err;
  logic       out_last;
  logic       page_err;
  logic       overflow;

  int total = 0;
  int bad = 0;
  int pops = 0;
  int rr_cnt = 0;

  entry_t exp_q[$];
  entry_t e;

  int m_acc = 0;
  int m_idx = 0;
  bit m_err = 0;

  always #5 clk = ~clk;

  mram_read_assembler #(
    .FIFO_DEPTH(4),
    .MAX_RETRY (3'd2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sa_valid  (sa_valid),
    .sa_trit   (sa_trit),
    .sa_meta   (sa_meta),
    .sa_last   (sa_last),
    .out_ready (out_ready),
    .in_ready  (in_ready),
    .reread_req(reread_req),
    .out_valid (out_valid),
    .out_byte  (out_byte),
    .out_err   (out_err),
    .out_last  (out_last),
    .page_err  (page_err),
    .overflow  (overflow)
  );

  always @(negedge clk) begin
    if (!rst && reread_req) rr_cnt++;
    if (!rst && out_valid && out_ready) begin
      total++;
      pops++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL pop_unexpected got=%0d/%0b/%0b want=none",
                 out_byte, out_err, out_last);
      end else begin
        e = exp_q.pop_front();
        if ({out_byte, out_err, out_last} !== {e.data, e.err, e.last}) begin
          bad++;
          $display("FAIL pop_byte got=%0d/%0b/%0b want=%0d/%0b/%0b",
                   out_byte, out_err, out_last, e.data, e.err, e.last);
        end
      end
    end
  end

  task automatic model_reset();
    m_acc = 0;
    m_idx = 0;
    m_err = 0;
  endtask

  task automatic model_accept(input logic [1:0] c, input bit meta,
                              input bit last);
    entry_t x;
    int v;
    v = (c == 2'b11) ? 0 : int'(c);
    m_acc += v * (3 ** m_idx);
    m_err |= (c == 2'b11) | meta;
    if (m_idx == TRITS_PER_BYTE - 1 || last) begin
      x.data = 8'(m_acc);
      x.err = m_err;
      x.last = last;
      exp_q.push_back(x);
      model_reset();
    end else begin
      m_idx++;
    end
  endtask

  // Called just after a posedge; returns just after the accepting edge.
  task automatic send(input logic [1:0] c, input bit meta, input bit last,
                      input bit accepted);
    int n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n == 200) begin
      total++;
      bad++;
      $display("FAIL send_timeout in_ready=%0b want=1", in_ready);
    end
    sa_valid = 1'b1;
    sa_trit = c;
    sa_meta = meta;
    sa_last = last;
    @(posedge clk);
    #1;
    sa_valid = 1'b0;
    sa_meta = 1'b0;
    sa_last = 1'b0;
    if (accepted) model_accept(c, meta, last);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    total++;
    if (n == 100) begin
      bad++;
      $display("FAIL %s_drain left=%0d want=0", name, exp_q.size());
    end
  endtask

  task automatic check_idle_outputs(input string name);
    total++;
    if ({reread_req, out_valid, out_byte, out_err, out_last,
         page_err, overflow} !== 14'b0) begin
      bad++;
      $display("FAIL %s_outs got=%0b%0b%0d%0b%0b%0b%0b want=all 0", name,
               reread_req, out_valid, out_byte, out_err, out_last,
               page_err, overflow);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle(3);
    total++;
    if (in_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_in_ready got=%0b want=0", in_ready);
    end
    check_idle_outputs("reset");
    rst = 1'b0;
    idle(1);
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_ready_after got=%0b want=1", in_ready);
    end
  endtask

  task automatic test_full_byte();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(2'b10, 0, 0, 1);
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL latency_early got=%0b want=0", out_valid);
    end
    idle(1);
    total++;
    if (out_valid !== 1'b1 || out_byte !== 8'd242) begin
      bad++;
      $display("FAIL latency_n1 got=%0b/%0d want=1/242", out_valid,
               out_byte);
    end
    out_ready = 1'b1;
    wait_drain("full_byte");
  endtask

  task automatic test_partial();
    send(2'b01, 0, 0, 1);
    for (int i = 0; i < 4; i++) send(2'b00, 0, 0, 1);
    send(2'b00, 0, 0, 1);
    send(2'b01, 0, 0, 1);
    send(2'b10, 0, 0, 1);
    send(2'b01, 0, 1, 1);
    wait_drain("partial");
  endtask

  task automatic test_illegal();
    send(2'b01, 0, 0, 1);
    send(2'b01, 0, 0, 1);
    send(2'b11, 0, 0, 1);
    send(2'b01, 0, 0, 1);
    send(2'b01, 0, 1, 1);
    wait_drain("illegal");
    total++;
    if (page_err !== 1'b1) begin
      bad++;
      $display("FAIL page_err_set got=%0b want=1", page_err);
    end
    send(2'b01, 0, 0, 1);
    total++;
    if (page_err !== 1'b0) begin
      bad++;
      $display("FAIL page_err_clear got=%0b want=0", page_err);
    end
    for (int i = 0; i < 4; i++) send(2'b01, 0, 0, 1);
    wait_drain("illegal_next");
  endtask

  task automatic test_overflow();
    out_ready = 1'b0;
    for (int g = 0; g < 4; g++)
      for (int i = 0; i < 5; i++) send(2'((g + i) % 3), 0, 0, 1);
    idle(1);
    total++;
    if (in_ready !== 1'b0) begin
      bad++;
      $display("FAIL full_in_ready got=%0b want=0", in_ready);
    end
    total++;
    if (out_byte !== exp_q[0].data) begin
      bad++;
      $display("FAIL stall_head got=%0d want=%0d", out_byte, exp_q[0].data);
    end
    sa_valid = 1'b1;
    sa_trit = 2'b01;
    idle(1);
    sa_valid = 1'b0;
    total++;
    if (overflow !== 1'b1) begin
      bad++;
      $display("FAIL overflow got=%0b want=1", overflow);
    end
    idle(2);
    total++;
    if (out_byte !== exp_q[0].data) begin
      bad++;
      $display("FAIL stall_hold got=%0d want=%0d", out_byte, exp_q[0].data);
    end
    out_ready = 1'b1;
    wait_drain("overflow");
  endtask

  task automatic test_meta();
    int rr0;
    int want;
    rr0 = rr_cnt;
`ifdef MRA_RETRY_EN
    send(2'b01, 1, 0, 0);
    idle(2);
    send(2'b01, 1, 0, 0);
    idle(2);
    want = 2;
`else
    want = 0;
`endif
    send(2'b01, 1, 0, 1);
    idle(2);
    for (int i = 0; i < 3; i++) send(2'b00, 0, 0, 1);
    send(2'b00, 0, 1, 1);
    wait_drain("meta");
    total++;
    if (rr_cnt - rr0 !== want) begin
      bad++;
      $display("FAIL reread_pulses got=%0d want=%0d", rr_cnt - rr0, want);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) send(2'b10, 0, 0, 0);
    rst = 1'b1;
    idle(2);
    check_idle_outputs("mid_reset");
    rst = 1'b0;
    model_reset();
    idle(3);
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL mid_no_byte got=%0b want=0", out_valid);
    end
    for (int i = 0; i < 5; i++) send(2'b01, 0, 0, 1);
    total++;
    if (exp_q.size() != 1 || exp_q[0].data !== 8'd121) begin
      bad++;
      $display("FAIL mid_model got=%0d want=121", exp_q[0].data);
    end
    wait_drain("mid_reset");
  endtask

  task automatic test_page();
    int p0;
    p0 = pops;
    for (int i = 0; i < PAGE_TRITS; i++)
      send(2'($urandom_range(0, 2)), 0, i == PAGE_TRITS - 1, 1);
    wait_drain("page");
    total++;
    if (pops - p0 != 146) begin
      bad++;
      $display("FAIL page_bytes got=%0d want=146", pops - p0);
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_full_byte();
    test_partial();
    test_illegal();
    test_overflow();
    test_meta();
    test_reset_mid();
    test_page();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
